// File: rtl/fft16_pkg.sv
// Shared encodings and widths for the 16-point FFT stage sequencer.
package fft16_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_ISSUE = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam int NUM_STAGES_DEF = 4;
  localparam int STAGE_W        = 2;
  localparam int LAT_W          = 4;

endpackage

// File: rtl/fft16_lat_timer.sv
// Loadable down-counter that times the butterfly latency of one stage.
module fft16_lat_timer
  import fft16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [LAT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - LAT_W'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/fft16_stage_seq.sv
// Frame sequencer for the 16-point radix-2 FFT: load, per-stage launch/wait/write-back,
// then hold the result until the sink takes it.
module fft16_stage_seq
  import fft16_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int STAGE_LAT  = 1,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               load_en,
  output logic               stage_en,
  output logic [STAGE_W-1:0] stage_sel,
  output logic               wb_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   frame_cnt
);

  if ((STAGE_LAT < 1) || (STAGE_LAT > 15)) begin : g_lat_check
    $error("fft16_stage_seq: STAGE_LAT must be within 1..15");
  end

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [LAT_W-1:0]   LAT_LOAD   = LAT_W'(STAGE_LAT - 1);

  state_t               state_reg;
  state_t               state_next;
  logic [STAGE_W-1:0]   stage_reg;
  logic [CNT_W-1:0]     frame_cnt_reg;
  logic                 ready_en_reg;
  logic                 timer_zero;

  // ready_en_reg keeps in_ready low while reset is held and releases it one edge later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ready_en_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (in_valid && in_ready) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (timer_zero) state_next = (stage_reg == LAST_STAGE) ? ST_DONE : ST_ISSUE;
      ST_DONE:  if (out_ready) state_next = in_valid ? ST_LOAD : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    load_en   = 1'b0;
    stage_en  = 1'b0;
    stage_sel = '0;
    wb_en     = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_reg)
      ST_IDLE:  in_ready = ready_en_reg;
      ST_LOAD:  begin load_en = 1'b1; busy = 1'b1; end
      ST_ISSUE: begin stage_en = 1'b1; stage_sel = stage_reg; busy = 1'b1; end
      ST_WAIT:  begin wb_en = timer_zero; stage_sel = stage_reg; busy = 1'b1; end
      // in_ready follows out_ready so a waiting frame can enter as the result leaves
      ST_DONE:  begin out_valid = 1'b1; busy = 1'b1; in_ready = out_ready; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg     <= '0;
      frame_cnt_reg <= '0;
    end else begin
      if (state_reg == ST_LOAD) begin
        stage_reg <= '0;
      end else if ((state_reg == ST_WAIT) && timer_zero && (stage_reg != LAST_STAGE)) begin
        stage_reg <= stage_reg + STAGE_W'(1);
      end
      if ((state_reg == ST_DONE) && out_ready) begin
        frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign frame_cnt = frame_cnt_reg;

  fft16_lat_timer u_lat_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_reg == ST_ISSUE),
    .load_val (LAT_LOAD),
    .en       (state_reg == ST_WAIT),
    .zero     (timer_zero)
  );

endmodule

// File: tb/tb_fft16_stage_seq.sv
// Directed bench for fft16_stage_seq: strobe timeline scoreboard plus handshake checks
// on a default-latency instance (a) and a STAGE_LAT=3 instance (b).
module tb_fft16_stage_seq;

  typedef struct {
    int cyc;
    int kind;  // 1 load, 2 stage launch, 3 write-back
    int sel;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  ev_t        q_a[$];
  ev_t        q_b[$];

  logic       a_in_valid, a_in_ready, a_load_en, a_stage_en, a_wb_en, a_out_valid, a_out_ready, a_busy;
  logic [1:0] a_stage_sel;
  logic [7:0] a_frame_cnt;
  logic       b_in_valid, b_in_ready, b_load_en, b_stage_en, b_wb_en, b_out_valid, b_out_ready, b_busy;
  logic [1:0] b_stage_sel;
  logic [7:0] b_frame_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft16_stage_seq #(.NUM_STAGES(4), .STAGE_LAT(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .load_en(a_load_en), .stage_en(a_stage_en), .stage_sel(a_stage_sel), .wb_en(a_wb_en),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .busy(a_busy), .frame_cnt(a_frame_cnt)
  );

  fft16_stage_seq #(.NUM_STAGES(4), .STAGE_LAT(3), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .load_en(b_load_en), .stage_en(b_stage_en), .stage_sel(b_stage_sel), .wb_en(b_wb_en),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .busy(b_busy), .frame_cnt(b_frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected strobe timeline for a frame handshaken at the end of cycle c0
  task automatic push_frame(input int dut, input int c0, input int lat);
    ev_t e;
    $display("frame on dut %s accepted at cycle %0d (STAGE_LAT=%0d)", (dut == 0) ? "a" : "b", c0, lat);
    for (int k = 0; k < 9; k++) begin
      if (k == 0) begin
        e.cyc = c0 + 1; e.kind = 1; e.sel = 0;
      end else if (k % 2 == 1) begin
        e.cyc = c0 + 2 + ((k - 1) / 2) * (1 + lat); e.kind = 2; e.sel = (k - 1) / 2;
      end else begin
        e.cyc = c0 + 2 + ((k - 2) / 2) * (1 + lat) + lat; e.kind = 3; e.sel = (k - 2) / 2;
      end
      if (dut == 0) q_a.push_back(e);
      else q_b.push_back(e);
    end
  endtask

  task automatic mon_step(input int dut, input logic ld, input logic st, input logic wb,
                          input logic [1:0] sel);
    ev_t   e;
    int    obs_k;
    int    exp_k;
    int    exp_sel;
    string tag;
    tag     = (dut == 0) ? "a" : "b";
    obs_k   = ld ? 1 : (st ? 2 : (wb ? 3 : 0));
    exp_k   = 0;
    exp_sel = 0;
    if (dut == 0) begin
      if (q_a.size() > 0 && q_a[0].cyc <= cyc) begin
        e = q_a.pop_front(); exp_k = e.kind; exp_sel = e.sel;
      end
    end else begin
      if (q_b.size() > 0 && q_b[0].cyc <= cyc) begin
        e = q_b.pop_front(); exp_k = e.kind; exp_sel = e.sel;
      end
    end
    if (obs_k != 0 || exp_k != 0) begin
      chk({tag, "_strobe_kind"}, obs_k, exp_k);
      chk({tag, "_strobe_sel"}, {30'd0, sel}, exp_sel);
      chk({tag, "_strobe_excl"}, int'(ld) + int'(st) + int'(wb), (exp_k != 0) ? 1 : 0);
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, a_load_en, a_stage_en, a_wb_en, a_stage_sel);
    mon_step(1, b_load_en, b_stage_en, b_wb_en, b_stage_sel);
  end

  task automatic chk_a_all_zero(input string tag);
    chk({tag, "_in_ready"}, a_in_ready, 0);
    chk({tag, "_load_en"}, a_load_en, 0);
    chk({tag, "_stage_en"}, a_stage_en, 0);
    chk({tag, "_stage_sel"}, a_stage_sel, 0);
    chk({tag, "_wb_en"}, a_wb_en, 0);
    chk({tag, "_out_valid"}, a_out_valid, 0);
    chk({tag, "_busy"}, a_busy, 0);
    chk({tag, "_frame_cnt"}, a_frame_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    tick(2);
    chk_a_all_zero("rst_hold");
    chk("rst_hold_b_busy", b_busy, 0);
    rst_n = 1'b1;

    // idle after release
    tick(5);
    chk("idle_in_ready", a_in_ready, 1);
    chk("idle_load_en", a_load_en, 0);
    chk("idle_stage_en", a_stage_en, 0);
    chk("idle_wb_en", a_wb_en, 0);
    chk("idle_out_valid", a_out_valid, 0);
    chk("idle_busy", a_busy, 0);
    chk("idle_frame_cnt", a_frame_cnt, 0);
    chk("idle_b_in_ready", b_in_ready, 1);

    // single frame, sink always ready
    c0 = cyc; a_out_ready = 1'b1; a_in_valid = 1'b1; push_frame(0, c0, 1);
    tick(1); a_in_valid = 1'b0;
    chk("f1_busy_load", a_busy, 1);
    chk("f1_in_ready_load", a_in_ready, 0);
    tick(8);
    chk("f1_out_valid_c9", a_out_valid, 0);
    tick(1);
    chk("f1_out_valid_c10", a_out_valid, 1);
    chk("f1_in_ready_done", a_in_ready, 1);
    chk("f1_frame_cnt_done", a_frame_cnt, 0);
    tick(1);
    chk("f1_out_valid_after", a_out_valid, 0);
    chk("f1_frame_cnt_after", a_frame_cnt, 1);
    chk("f1_busy_after", a_busy, 0);

    // sink stalls for 7 cycles in DONE
    c0 = cyc; a_out_ready = 1'b0; a_in_valid = 1'b1; push_frame(0, c0, 1);
    tick(1); a_in_valid = 1'b0;
    tick(9);
    for (int i = 0; i < 7; i++) begin
      chk("stall_out_valid", a_out_valid, 1);
      chk("stall_in_ready", a_in_ready, 0);
      chk("stall_frame_cnt", a_frame_cnt, 1);
      tick(1);
    end
    a_out_ready = 1'b1;
    #1;
    chk("stall_release_in_ready", a_in_ready, 1);
    tick(1);
    chk("stall_out_valid_after", a_out_valid, 0);
    chk("stall_frame_cnt_after", a_frame_cnt, 2);

    // in_valid held high: back-to-back frames every 10 cycles
    c0 = cyc; a_in_valid = 1'b1;
    push_frame(0, c0, 1); push_frame(0, c0 + 10, 1); push_frame(0, c0 + 20, 1);
    tick(10);
    chk("b2b_out_valid_1", a_out_valid, 1);
    chk("b2b_in_ready_1", a_in_ready, 1);
    tick(1);
    chk("b2b_busy_reload", a_busy, 1);
    chk("b2b_frame_cnt_1", a_frame_cnt, 3);
    tick(9);
    chk("b2b_out_valid_2", a_out_valid, 1);
    tick(1); a_in_valid = 1'b0;
    chk("b2b_frame_cnt_2", a_frame_cnt, 4);
    tick(9);
    chk("b2b_out_valid_3", a_out_valid, 1);
    tick(1);
    chk("b2b_frame_cnt_3", a_frame_cnt, 5);
    chk("b2b_busy_end", a_busy, 0);

    // STAGE_LAT=3 instance
    c0 = cyc; b_out_ready = 1'b1; b_in_valid = 1'b1; push_frame(1, c0, 3);
    tick(1); b_in_valid = 1'b0;
    chk("lat3_in_ready_load", b_in_ready, 0);
    tick(16);
    chk("lat3_out_valid_c17", b_out_valid, 0);
    tick(1);
    chk("lat3_out_valid_c18", b_out_valid, 1);
    tick(1);
    chk("lat3_frame_cnt", b_frame_cnt, 1);
    chk("lat3_busy_end", b_busy, 0);

    // reset during the write-back cycle of stage 2
    c0 = cyc; a_in_valid = 1'b1; push_frame(0, c0, 1);
    tick(1); a_in_valid = 1'b0;
    tick(6);
    chk("mid_stage_sel", a_stage_sel, 2);
    chk("mid_wb_en", a_wb_en, 1);
    rst_n = 1'b0;
    q_a.delete();
    #1;
    chk_a_all_zero("mid_rst");
    chk("mid_rst_b_frame_cnt", b_frame_cnt, 0);
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk("post_rst_out_valid", a_out_valid, 0);
      chk("post_rst_wb_en", a_wb_en, 0);
      tick(1);
    end
    chk("post_rst_in_ready", a_in_ready, 1);

    // fresh frame after reset
    c0 = cyc; a_in_valid = 1'b1; push_frame(0, c0, 1);
    tick(1); a_in_valid = 1'b0;
    tick(9);
    chk("post_rst_frame_out_valid", a_out_valid, 1);
    tick(1);
    chk("post_rst_frame_cnt", a_frame_cnt, 1);
    tick(2);
    chk("a_events_left", q_a.size(), 0);
    chk("b_events_left", q_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
